// File: rtl/uart_rx_ctrl.sv
// Shadow config + restart sequencing for uart_rcv, FWFT byte FIFO (byte visible 1 cycle after rcv_en),
// valid/ready consumer side; a store into a full FIFO without a same-cycle pop is dropped and flagged as overrun.
module uart_rx_ctrl #(
  parameter int SAMPLE_WIDTH_BITS = 15,
  parameter int DEF_SAMPLE_WIDTH  = 26,
  parameter int FIFO_DEPTH        = 8,
  parameter int RESTART_CYCLES    = 4
) (
  input  logic                          clk,
  input  logic                          nRst,
  input  logic                          cfg_wr,
  input  logic [SAMPLE_WIDTH_BITS-1:0]  cfg_sample_width,
  input  logic                          cfg_en_parity,
  input  logic                          cfg_odd_parity,
  input  logic [1:0]                    cfg_data_bits,
  output logic                          rcv_nRst,
  output logic [SAMPLE_WIDTH_BITS-1:0]  sample_width,
  output logic                          en_parity,
  output logic                          odd_parity,
  output logic [1:0]                    data_bits,
  input  logic                          rcv_en,
  input  logic [7:0]                    rcv_data,
  input  logic                          rcv_parity_valid,
  input  logic                          drop_bad,
  output logic                          m_valid,
  output logic [7:0]                    m_data,
  output logic                          m_perr,
  input  logic                          m_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overrun,
  output logic [7:0]                    perr_cnt,
  input  logic                          clr_status
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = $clog2(RESTART_CYCLES) + 1;

  typedef enum logic {RESTART = 1'b0, RUN = 1'b1} state_t;

  state_t                         state_q, state_d;
  logic [CW-1:0]                  cnt_q, cnt_d;
  logic [SAMPLE_WIDTH_BITS-1:0]   sample_width_q;
  logic                           en_parity_q, odd_parity_q;
  logic [1:0]                     data_bits_q;
  logic [8:0]                     mem_q [FIFO_DEPTH];
  logic [AW-1:0]                  wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]                  level_q, level_d;
  logic                           overrun_q, overrun_d;
  logic [7:0]                     perr_cnt_q, perr_cnt_d;
  logic                           accept, perr, store, pop, full, push, lost;
  logic [8:0]                     head;

  always_ff @(posedge clk) begin
    if (!nRst) begin
      state_q <= RESTART;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // A config write restarts the receiver from either state, so it also stretches an ongoing restart.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (cfg_wr) begin
      state_d = RESTART;
      cnt_d   = '0;
    end else begin
      case (state_q)
        RESTART: begin
          if (cnt_q == CW'(RESTART_CYCLES - 1)) begin
            state_d = RUN;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign rcv_nRst = (state_q == RUN);

  always_ff @(posedge clk) begin
    if (!nRst) begin
      sample_width_q <= SAMPLE_WIDTH_BITS'(DEF_SAMPLE_WIDTH);
      en_parity_q    <= 1'b0;
      odd_parity_q   <= 1'b0;
      data_bits_q    <= 2'd0;
    end else if (cfg_wr) begin
      sample_width_q <= cfg_sample_width;
      en_parity_q    <= cfg_en_parity;
      odd_parity_q   <= cfg_odd_parity;
      data_bits_q    <= cfg_data_bits;
    end
  end

  assign sample_width = sample_width_q;
  assign en_parity    = en_parity_q;
  assign odd_parity   = odd_parity_q;
  assign data_bits    = data_bits_q;

  assign accept = (state_q == RUN) & rcv_en;
  assign perr   = en_parity_q & ~rcv_parity_valid;
  assign store  = accept & ~(drop_bad & perr);
  assign m_valid = (level_q != '0);
  assign pop    = m_valid & m_ready;
  assign full   = (level_q == LW'(FIFO_DEPTH));
  assign push   = store & (~full | pop);
  assign lost   = store & full & ~pop;

  always_comb begin
    level_d = level_q + LW'(push) - LW'(pop);
  end

  always_ff @(posedge clk) begin
    if (!nRst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      level_q <= level_d;
    end
  end

  // Storage needs no reset: the head is masked whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {perr, rcv_data};
  end

  assign head       = mem_q[rd_ptr_q];
  assign m_data     = m_valid ? head[7:0] : 8'h00;
  assign m_perr     = m_valid ? head[8] : 1'b0;
  assign fifo_level = level_q;

  // A same-cycle event beats clr_status.
  always_comb begin
    overrun_d  = clr_status ? 1'b0 : overrun_q;
    perr_cnt_d = clr_status ? 8'h00 : perr_cnt_q;
    if (lost) overrun_d = 1'b1;
    if (accept & perr) begin
      if (clr_status)                perr_cnt_d = 8'h01;
      else if (perr_cnt_q != 8'hFF)  perr_cnt_d = perr_cnt_q + 8'h01;
    end
  end

  always_ff @(posedge clk) begin
    if (!nRst) begin
      overrun_q  <= 1'b0;
      perr_cnt_q <= 8'h00;
    end else begin
      overrun_q  <= overrun_d;
      perr_cnt_q <= perr_cnt_d;
    end
  end

  assign overrun  = overrun_q;
  assign perr_cnt = perr_cnt_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Bench for uart_rx_ctrl: directed stimulus with an expected-byte queue popped by a handshake monitor.
module tb_uart_rx_ctrl;

  logic        clk = 1'b0;
  logic        nRst;
  logic        cfg_wr;
  logic [14:0] cfg_sample_width;
  logic        cfg_en_parity, cfg_odd_parity;
  logic [1:0]  cfg_data_bits;
  logic        rcv_nRst;
  logic [14:0] sample_width;
  logic        en_parity, odd_parity;
  logic [1:0]  data_bits;
  logic        rcv_en;
  logic [7:0]  rcv_data;
  logic        rcv_parity_valid, drop_bad;
  logic        m_valid;
  logic [7:0]  m_data;
  logic        m_perr, m_ready;
  logic [3:0]  fifo_level;
  logic        overrun;
  logic [7:0]  perr_cnt;
  logic        clr_status;

  int checks = 0;
  int failures = 0;
  logic [8:0] exp_q[$];

  uart_rx_ctrl dut (
    .clk(clk), .nRst(nRst), .cfg_wr(cfg_wr), .cfg_sample_width(cfg_sample_width),
    .cfg_en_parity(cfg_en_parity), .cfg_odd_parity(cfg_odd_parity), .cfg_data_bits(cfg_data_bits),
    .rcv_nRst(rcv_nRst), .sample_width(sample_width), .en_parity(en_parity),
    .odd_parity(odd_parity), .data_bits(data_bits), .rcv_en(rcv_en), .rcv_data(rcv_data),
    .rcv_parity_valid(rcv_parity_valid), .drop_bad(drop_bad), .m_valid(m_valid),
    .m_data(m_data), .m_perr(m_perr), .m_ready(m_ready), .fifo_level(fifo_level),
    .overrun(overrun), .perr_cnt(perr_cnt), .clr_status(clr_status)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_run(input string name);
    int n = 0;
    while (!rcv_nRst && n < 20) begin
      n++;
      tick();
    end
    check(name, n, 4);
  endtask

  task automatic cfg(input logic [14:0] sw, input logic ep, input logic op, input logic [1:0] db);
    cfg_sample_width = sw; cfg_en_parity = ep; cfg_odd_parity = op; cfg_data_bits = db;
    cfg_wr = 1'b1;
    tick();
    cfg_wr = 1'b0;
  endtask

  task automatic drain(input int expect_n);
    int n = 0;
    m_ready = 1'b1;
    while (m_valid && n < 20) begin
      n++;
      tick();
    end
    m_ready = 1'b0;
    check("drain_count", n, expect_n);
    check("drain_level", fifo_level, 0);
  endtask

  initial begin : sim_timeout
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    nRst = 1'b0; cfg_wr = 1'b0; cfg_sample_width = '0; cfg_en_parity = 1'b0;
    cfg_odd_parity = 1'b0; cfg_data_bits = 2'd0; rcv_en = 1'b0; rcv_data = 8'h00;
    rcv_parity_valid = 1'b1; drop_bad = 1'b0; m_ready = 1'b0; clr_status = 1'b0;

    fork
      forever begin
        @(negedge clk);
        if (nRst && m_valid && m_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL pop_unexpected: got 0x%0h expected no output", {m_perr, m_data});
          end else begin
            check("pop_data", {m_perr, m_data}, exp_q.pop_front());
          end
        end
      end
    join_none

    tick(); tick(); tick();
    check("rst_rcv_nRst", rcv_nRst, 0);
    check("rst_sample_width", sample_width, 26);
    check("rst_data_bits", data_bits, 0);
    check("rst_m_valid", m_valid, 0);
    check("rst_m_data", m_data, 0);
    check("rst_level", fifo_level, 0);
    check("rst_overrun", overrun, 0);
    check("rst_perr_cnt", perr_cnt, 0);
    nRst = 1'b1;
    wait_run("restart_after_reset");

    // Single byte, parity disabled
    rcv_en = 1'b1; rcv_data = 8'h5A; rcv_parity_valid = 1'b1;
    exp_q.push_back({1'b0, 8'h5A});
    tick();
    rcv_en = 1'b0;
    check("byte_m_valid", m_valid, 1);
    check("byte_m_data", m_data, 8'h5A);
    check("byte_m_perr", m_perr, 0);
    check("byte_level", fifo_level, 1);
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    check("byte_popped", m_valid, 0);

    // Parity errors: dropped then stored
    cfg(15'd26, 1'b1, 1'b0, 2'd0);
    check("cfg_en_parity", en_parity, 1);
    wait_run("restart_parity_cfg");
    drop_bad = 1'b1; rcv_en = 1'b1; rcv_data = 8'h33; rcv_parity_valid = 1'b0;
    tick();
    rcv_en = 1'b0;
    check("drop_perr_cnt", perr_cnt, 1);
    check("drop_level", fifo_level, 0);
    drop_bad = 1'b0; rcv_en = 1'b1;
    exp_q.push_back({1'b1, 8'h33});
    tick();
    rcv_en = 1'b0;
    check("keep_perr_cnt", perr_cnt, 2);
    check("keep_m_data", m_data, 8'h33);
    check("keep_m_perr", m_perr, 1);
    rcv_parity_valid = 1'b1; rcv_en = 1'b1; rcv_data = 8'h44;
    exp_q.push_back({1'b0, 8'h44});
    tick();
    rcv_en = 1'b0;
    check("good_parity_cnt", perr_cnt, 2);
    drain(2);

    // Fill, overrun, push+pop while full
    rcv_en = 1'b1; rcv_parity_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      rcv_data = 8'(i);
      exp_q.push_back({1'b0, 8'(i)});
      tick();
    end
    rcv_data = 8'h08;
    tick();
    rcv_en = 1'b0;
    check("full_overrun", overrun, 1);
    check("full_level", fifo_level, 8);
    check("full_head_held", m_data, 8'h00);
    clr_status = 1'b1;
    tick();
    clr_status = 1'b0;
    check("clr_overrun", overrun, 0);
    check("clr_perr_cnt", perr_cnt, 0);
    rcv_en = 1'b1; rcv_data = 8'h09; m_ready = 1'b1;
    exp_q.push_back({1'b0, 8'h09});
    tick();
    rcv_en = 1'b0; m_ready = 1'b0;
    check("fullpop_level", fifo_level, 8);
    check("fullpop_overrun", overrun, 0);
    check("fullpop_head", m_data, 8'h01);
    drain(8);

    // Config write with 2 bytes buffered; bytes during restart ignored
    rcv_en = 1'b1; rcv_data = 8'hA1;
    exp_q.push_back({1'b0, 8'hA1});
    tick();
    rcv_data = 8'hA2;
    exp_q.push_back({1'b0, 8'hA2});
    tick();
    rcv_en = 1'b0;
    cfg(15'd9, 1'b0, 1'b1, 2'd1);
    check("cfg_sample_width", sample_width, 9);
    check("cfg_data_bits", data_bits, 1);
    check("cfg_odd_parity", odd_parity, 1);
    check("cfg_en_parity_off", en_parity, 0);
    rcv_en = 1'b1; rcv_data = 8'hEE;
    wait_run("restart_cfg_write");
    rcv_en = 1'b0;
    check("cfg_level_kept", fifo_level, 2);
    check("cfg_head_kept", m_data, 8'hA1);
    drain(2);

    // Parity-error counter saturation and clear collision
    cfg(15'd9, 1'b1, 1'b0, 2'd1);
    wait_run("restart_sat_cfg");
    drop_bad = 1'b1; rcv_parity_valid = 1'b0; rcv_en = 1'b1;
    for (int i = 0; i < 255; i++) tick();
    check("sat_255", perr_cnt, 255);
    tick();
    check("sat_hold", perr_cnt, 255);
    check("sat_no_store", fifo_level, 0);
    clr_status = 1'b1;
    tick();
    rcv_en = 1'b0;
    check("clr_vs_perr", perr_cnt, 1);
    tick();
    clr_status = 1'b0;
    check("clr_alone", perr_cnt, 0);
    drop_bad = 1'b0; rcv_parity_valid = 1'b1;

    // Reset mid-operation loses FIFO contents and config
    rcv_en = 1'b1; rcv_data = 8'h77;
    tick();
    rcv_en = 1'b0;
    check("pre_rst_level", fifo_level, 1);
    nRst = 1'b0;
    tick();
    check("mid_rst_level", fifo_level, 0);
    check("mid_rst_m_valid", m_valid, 0);
    check("mid_rst_sample_width", sample_width, 26);
    check("mid_rst_rcv_nRst", rcv_nRst, 0);
    check("mid_rst_en_parity", en_parity, 0);
    nRst = 1'b1;
    wait_run("restart_after_mid_reset");

    check("scoreboard_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_rx_ctrl.md
Name: uart_rx_ctrl

Overview:
- Control and buffering stage placed directly behind the UART receive datapath (uart_rcv).
- Holds the receiver's line configuration and applies it in shadow; every configuration change is followed by a clean receiver restart.
- Catches each received byte into a first-word-fall-through FIFO and presents it to the consumer with a valid/ready handshake.
- Keeps status: sticky overrun flag and a saturating parity-error count.

Parameters:
SAMPLE_WIDTH_BITS, 15, width of the sample_width configuration field
DEF_SAMPLE_WIDTH, 26, sample_width value loaded at reset (sample width - 1)
FIFO_DEPTH, 8, FIFO entries; power of two, >= 2
RESTART_CYCLES, 4, cycles rcv_nRst is held low after reset or a config write; >= 1

Ports:
clk  in  1  clock
nRst  in  1  synchronous active-low reset
cfg_wr  in  1  one-cycle strobe; loads all cfg_* fields
cfg_sample_width  in  SAMPLE_WIDTH_BITS  new sample width - 1
cfg_en_parity  in  1  new parity enable
cfg_odd_parity  in  1  new odd-parity select
cfg_data_bits  in  2  new data-bit code (5=>1, 6=>2, 7=>3, 8=>0)
rcv_nRst  out  1  reset to the receiver, active low
sample_width  out  SAMPLE_WIDTH_BITS  to receiver
en_parity  out  1  to receiver
odd_parity  out  1  to receiver
data_bits  out  2  to receiver
rcv_en  in  1  receiver byte-done pulse
rcv_data  in  8  receiver byte
rcv_parity_valid  in  1  receiver parity result
drop_bad  in  1  when 1, bytes with a parity error are not stored
m_valid  out  1  FIFO head valid
m_data  out  8  FIFO head byte
m_perr  out  1  parity-error tag of the head byte
m_ready  in  1  consumer accepts the head byte
fifo_level  out  $clog2(FIFO_DEPTH)+1  number of stored entries
overrun  out  1  sticky; a byte was lost because the FIFO was full
perr_cnt  out  8  saturating parity-error count
clr_status  in  1  clears overrun and perr_cnt

Behaviour:
- Interface: one clock, clk. nRst is synchronous and active-low; every register updates only on the rising edge of clk.
- Reset values:
  - state=RESTART, restart counter=0, rcv_nRst=0
  - sample_width=DEF_SAMPLE_WIDTH, en_parity=0, odd_parity=0, data_bits=0
  - FIFO empty: m_valid=0, fifo_level=0, m_data=0, m_perr=0
  - overrun=0, perr_cnt=0
- States:
  - RESTART: rcv_nRst=0; counter increments each cycle; moves to RUN on the cycle counter==RESTART_CYCLES-1. rcv_nRst therefore stays low for exactly RESTART_CYCLES cycles after reset release.
  - RUN: rcv_nRst=1; received bytes are accepted.
- cfg_wr (either state):
  - All cfg_* fields are registered into the config outputs the next cycle.
  - State goes to RESTART and the counter reloads to 0; a cfg_wr during RESTART extends it.
  - The FIFO is not flushed.
- Byte acceptance (only in RUN with rcv_en=1; rcv_en is ignored in RESTART):
  - perr = en_parity & ~rcv_parity_valid; when en_parity=0, perr is always 0.
  - perr=1: perr_cnt increments, saturating at 255, whether or not the byte is dropped.
  - Store attempt when ~(drop_bad & perr); the entry is {perr, rcv_data}.
- FIFO:
  - First-word-fall-through; m_valid = (fifo_level != 0).
  - Pop on m_valid & m_ready.
  - A pushed byte is visible at m_data one cycle after rcv_en.
  - Store while full without a same-cycle pop: byte discarded, overrun set to 1, level unchanged.
  - Store while full with a same-cycle pop: both take effect, level stays FIFO_DEPTH, no overrun.
  - Store while empty with m_ready=1: no bypass; the byte appears next cycle.
  - Pointers wrap modulo FIFO_DEPTH.
  - m_data and m_perr are held stable while m_valid=1 and m_ready=0.
- clr_status:
  - Clears overrun and perr_cnt.
  - If a new overrun or parity error occurs in the same cycle, the event wins: overrun=1 or perr_cnt=1.
- nRst low in mid-operation: all state returns to its reset values on the next edge; FIFO contents are lost.

Test Plan:
- Release reset -> rcv_nRst low for exactly 4 cycles, then high; sample_width=26, data_bits=0, m_valid=0.
- In RUN, pulse rcv_en with rcv_data=0x5A, parity valid -> next cycle m_valid=1, m_data=0x5A, m_perr=0, fifo_level=1; m_ready=1 for one cycle -> m_valid=0.
- en_parity=1; pulse rcv_en with data 0x33, rcv_parity_valid=0:
  - drop_bad=1 -> perr_cnt=1, fifo_level=0
  - repeat with drop_bad=0 -> perr_cnt=2, m_data=0x33, m_perr=1
- Push 8 bytes 0x00..0x07 with m_ready=0, then push 0x08:
  - overrun=1, fifo_level=8, byte 0x08 lost
  - drain -> 0x00..0x07 in order
  - push while full and popping in the same cycle -> no overrun, level stays 8
- cfg_wr with sample_width=9, data_bits=1 while FIFO holds 2 bytes:
  - next cycle outputs updated and rcv_nRst low for 4 cycles
  - rcv_en in that window ignored
  - FIFO still holds 2 bytes
- perr_cnt=255 plus another parity error -> stays 255; clr_status in the same cycle as a parity error -> perr_cnt=1.
